id_exe_stage: RTL and testbench
===============================

# id_exe_stage

Parametrised ID/EXE pipeline stage that replaces the fixed 32-bit decode-to-execute latch. It registers the decode bundle (control, operands, sign-extended immediate, destination register) into the execute stage. It adds valid tracking, external stall, flush-to-bubble, load-use hazard detection with bubble insertion, and MEM/WB operand forwarding at capture. It sits between the control unit / register file / sign-extend logic and the ALU.

## Interface
- DATA_W, 32, operand/immediate width
- RA_W, 5, register address width
- ALUC_W, 4, ALU control width
- CNT_W, 16, bubble counter width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_wreg, id_m2reg, id_wmem, id_aluimm  in  1 each  decoded controls
- id_aluc  in  ALUC_W  decoded ALU op
- id_rs, id_rt  in  RA_W  source register numbers
- id_uses_rt  in  1  rt is a source; 0 for I-type loads/ALU-immediate
- id_dest  in  RA_W  destination after the regrt mux
- id_qa, id_qb, id_imm  in  DATA_W  register-file reads, sign-extended immediate
- flush  in  1  squash the decode slot (branch/jump redirect)
- ext_stall  in  1  hold the whole stage (downstream stall)
- m_wreg, m_dest, m_res  in  1/RA_W/DATA_W  MEM-stage writeback source
- w_wreg, w_dest, w_data  in  1/RA_W/DATA_W  WB-stage writeback source
- e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm  out  1 each  registered controls
- e_aluc  out  ALUC_W; e_dest  out  RA_W; e_qa, e_qb, e_imm  out  DATA_W
- load_use_stall  out  1  combinational; freezes PC and IF/ID
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles

## Operation
- Load-use hazard is evaluated combinationally: load_use_stall = e_valid & e_wreg & e_m2reg & (e_dest != 0) & id_valid & ((e_dest == id_rs) | (id_uses_rt & e_dest == id_rt)).
- Per-edge priority: rst > ext_stall > flush > load_use_stall > capture.
  - rst: all outputs 0, bubble_cnt 0.
  - ext_stall: every register holds, including bubble_cnt. load_use_stall keeps being computed from held state.
  - flush or load_use_stall: insert a bubble. e_valid and all controls go to 0; e_aluc, e_dest, e_qa, e_qb and e_imm also go to 0. bubble_cnt increments by 1, saturating at all-ones. Flush and load-use in the same cycle count as one bubble.
  - Capture: every e_* register takes its id_* value, with e_valid = id_valid. id_valid=0 is latched as-is and is not counted as a bubble.
- Forwarding applies to qa (from rs) and qb (from rt) at capture.
  - Forward from MEM when m_wreg & m_dest == src & src != 0; otherwise from WB when w_wreg & w_dest == src & src != 0; otherwise from the register file.
  - MEM has priority over WB. Register 0 is never forwarded.
  - qb is forwarded regardless of id_uses_rt, because stores need rt.
- EXE-to-EXE forwarding belongs in the ALU input mux and is out of scope for this block.

## Timing
- All e_* outputs are registered: one cycle of latency from id_* to e_*.
- load_use_stall is purely combinational, with zero latency. The upstream stages must not feed it back into id_valid within the same cycle.
- A load followed immediately by a dependent instruction costs exactly one bubble. On the next cycle the load is in MEM, and the dependent instruction captures through the MEM forwarding path (m_res must carry the load data).
- Reset mid-stall or mid-flush clears the stage on that edge. load_use_stall is 0 on the cycle after reset.

## Structure
- Package cpu_pipe_pkg: DATA_W, RA_W and ALUC_W defaults, plus a packed typedef ctrl_t {valid, wreg, m2reg, wmem, aluimm, aluc}. A bubble is ctrl_t of all zeros.
- Sub-module hazard_unit: load-use comparator plus the two forwarding-select muxes, purely combinational.
- The top level holds the pipeline registers and the saturating counter.

## Test plan
- Plain capture: id_valid=1, id_qa=0x11, id_qb=0x22, id_imm=0xFFFFFFF0, id_dest=3 -> next edge e_qa=0x11, e_qb=0x22, e_imm=0xFFFFFFF0, e_dest=3, e_valid=1.
- Load-use: stage holds lw to r5 (e_m2reg=1, e_wreg=1); decode has add with rs=5 -> load_use_stall=1, next edge is a bubble, bubble_cnt=1. With id_uses_rt=0 and rt=5 -> no stall.
- Forwarding priority: m_dest=w_dest=id_rs=7, m_res=0xAA, w_data=0xBB, id_qa=0xCC -> e_qa=0xAA. With m_wreg=0 -> 0xBB. With rs=0 -> 0xCC.
- Stall and flush together: ext_stall=1 with flush=1 -> outputs and bubble_cnt unchanged. After ext_stall drops, flush alone -> bubble, counter +1.
- Saturation: CNT_W=2, four consecutive flushes -> bubble_cnt 1,2,3,3.
- Reset: assert rst while a stall is in progress -> all outputs 0 on the next edge, bubble_cnt=0, load_use_stall=0.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared widths and the control bundle carried from decode into execute.
// An all-zero ctrl_t is a bubble.
package cpu_pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_RA_W   = 5;
  localparam int ALUC_W     = 4;

  typedef struct packed {
    logic              valid;
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic              aluimm;
    logic [ALUC_W-1:0] aluc;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_exe_stage_if.sv
// Decode-side bundle, MEM/WB writeback sources and registered execute-side
// outputs of the ID/EXE stage. The master drives decode; the slave is the stage.
interface id_exe_stage_if #(
  parameter int DATA_W = cpu_pipe_pkg::DEF_DATA_W,
  parameter int RA_W   = cpu_pipe_pkg::DEF_RA_W,
  parameter int ALUC_W = cpu_pipe_pkg::ALUC_W,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic              id_wreg;
  logic              id_m2reg;
  logic              id_wmem;
  logic              id_aluimm;
  logic [ALUC_W-1:0] id_aluc;
  logic [RA_W-1:0]   id_rs;
  logic [RA_W-1:0]   id_rt;
  logic              id_uses_rt;
  logic [RA_W-1:0]   id_dest;
  logic [DATA_W-1:0] id_qa;
  logic [DATA_W-1:0] id_qb;
  logic [DATA_W-1:0] id_imm;
  logic              flush;
  logic              ext_stall;
  logic              m_wreg;
  logic [RA_W-1:0]   m_dest;
  logic [DATA_W-1:0] m_res;
  logic              w_wreg;
  logic [RA_W-1:0]   w_dest;
  logic [DATA_W-1:0] w_data;

  logic              e_valid;
  logic              e_wreg;
  logic              e_m2reg;
  logic              e_wmem;
  logic              e_aluimm;
  logic [ALUC_W-1:0] e_aluc;
  logic [RA_W-1:0]   e_dest;
  logic [DATA_W-1:0] e_qa;
  logic [DATA_W-1:0] e_qb;
  logic [DATA_W-1:0] e_imm;
  logic              load_use_stall;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output id_valid, id_wreg, id_m2reg, id_wmem, id_aluimm, id_aluc,
           id_rs, id_rt, id_uses_rt, id_dest, id_qa, id_qb, id_imm,
           flush, ext_stall, m_wreg, m_dest, m_res, w_wreg, w_dest, w_data,
    input  e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm, e_aluc, e_dest,
           e_qa, e_qb, e_imm, load_use_stall, bubble_cnt
  );

  modport slave (
    input  id_valid, id_wreg, id_m2reg, id_wmem, id_aluimm, id_aluc,
           id_rs, id_rt, id_uses_rt, id_dest, id_qa, id_qb, id_imm,
           flush, ext_stall, m_wreg, m_dest, m_res, w_wreg, w_dest, w_data,
    output e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm, e_aluc, e_dest,
           e_qa, e_qb, e_imm, load_use_stall, bubble_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Load-use comparator and MEM/WB operand forwarding selects, purely combinational.
module hazard_unit #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              e_valid_i,
  input  logic              e_wreg_i,
  input  logic              e_m2reg_i,
  input  logic [RA_W-1:0]   e_dest_i,
  input  logic              id_valid_i,
  input  logic [RA_W-1:0]   id_rs_i,
  input  logic [RA_W-1:0]   id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic [DATA_W-1:0] id_qa_i,
  input  logic [DATA_W-1:0] id_qb_i,
  input  logic              m_wreg_i,
  input  logic [RA_W-1:0]   m_dest_i,
  input  logic [DATA_W-1:0] m_res_i,
  input  logic              w_wreg_i,
  input  logic [RA_W-1:0]   w_dest_i,
  input  logic [DATA_W-1:0] w_data_i,
  output logic              load_use_stall_o,
  output logic [DATA_W-1:0] fwd_qa_o,
  output logic [DATA_W-1:0] fwd_qb_o
);

  // MEM beats WB; r0 is hardwired zero so it never takes a forwarded value.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [RA_W-1:0]   src,
    input logic [DATA_W-1:0] rf,
    input logic              mw,
    input logic [RA_W-1:0]   md,
    input logic [DATA_W-1:0] mres,
    input logic              ww,
    input logic [RA_W-1:0]   wd,
    input logic [DATA_W-1:0] wdat
  );
    if (src == '0)              return rf;
    else if (mw && (md == src)) return mres;
    else if (ww && (wd == src)) return wdat;
    else                        return rf;
  endfunction

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (e_dest_i == id_rs_i);
  assign rt_hit = id_uses_rt_i && (e_dest_i == id_rt_i);

  assign load_use_stall_o = e_valid_i && e_wreg_i && e_m2reg_i && (e_dest_i != '0) &&
                            id_valid_i && (rs_hit || rt_hit);

  // qb is forwarded even when rt is not an ALU source: stores read it.
  assign fwd_qa_o = fwd_sel(id_rs_i, id_qa_i, m_wreg_i, m_dest_i, m_res_i,
                            w_wreg_i, w_dest_i, w_data_i);
  assign fwd_qb_o = fwd_sel(id_rt_i, id_qb_i, m_wreg_i, m_dest_i, m_res_i,
                            w_wreg_i, w_dest_i, w_data_i);

endmodule

// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register with valid tracking, stall, flush-to-bubble,
// load-use bubble insertion, MEM/WB forwarding at capture and a bubble counter.
module id_exe_stage
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RA_W   = DEF_RA_W,
  parameter int CNT_W  = 16
) (
  input  logic        clk,
  input  logic        rst,
  id_exe_stage_if.slave bus
);

  ctrl_t             ctrl_q, ctrl_d;
  logic [RA_W-1:0]   dest_q, dest_d;
  logic [DATA_W-1:0] qa_q, qa_d;
  logic [DATA_W-1:0] qb_q, qb_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              load_use;
  logic [DATA_W-1:0] fwd_qa;
  logic [DATA_W-1:0] fwd_qb;

  hazard_unit #(.DATA_W(DATA_W), .RA_W(RA_W)) u_hazard (
    .e_valid_i        (ctrl_q.valid),
    .e_wreg_i         (ctrl_q.wreg),
    .e_m2reg_i        (ctrl_q.m2reg),
    .e_dest_i         (dest_q),
    .id_valid_i       (bus.id_valid),
    .id_rs_i          (bus.id_rs),
    .id_rt_i          (bus.id_rt),
    .id_uses_rt_i     (bus.id_uses_rt),
    .id_qa_i          (bus.id_qa),
    .id_qb_i          (bus.id_qb),
    .m_wreg_i         (bus.m_wreg),
    .m_dest_i         (bus.m_dest),
    .m_res_i          (bus.m_res),
    .w_wreg_i         (bus.w_wreg),
    .w_dest_i         (bus.w_dest),
    .w_data_i         (bus.w_data),
    .load_use_stall_o (load_use),
    .fwd_qa_o         (fwd_qa),
    .fwd_qb_o         (fwd_qb)
  );

  // ext_stall freezes everything; flush and load-use share one bubble path.
  always_comb begin
    ctrl_d = ctrl_q;
    dest_d = dest_q;
    qa_d   = qa_q;
    qb_d   = qb_q;
    imm_d  = imm_q;
    cnt_d  = cnt_q;
    if (!bus.ext_stall) begin
      if (bus.flush || load_use) begin
        ctrl_d = CTRL_BUBBLE;
        dest_d = '0;
        qa_d   = '0;
        qb_d   = '0;
        imm_d  = '0;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end else begin
        ctrl_d.valid  = bus.id_valid;
        ctrl_d.wreg   = bus.id_wreg;
        ctrl_d.m2reg  = bus.id_m2reg;
        ctrl_d.wmem   = bus.id_wmem;
        ctrl_d.aluimm = bus.id_aluimm;
        ctrl_d.aluc   = bus.id_aluc;
        dest_d        = bus.id_dest;
        qa_d          = fwd_qa;
        qb_d          = fwd_qb;
        imm_d         = bus.id_imm;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= CTRL_BUBBLE;
      dest_q <= '0;
      qa_q   <= '0;
      qb_q   <= '0;
      imm_q  <= '0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      dest_q <= dest_d;
      qa_q   <= qa_d;
      qb_q   <= qb_d;
      imm_q  <= imm_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.e_valid        = ctrl_q.valid;
  assign bus.e_wreg         = ctrl_q.wreg;
  assign bus.e_m2reg        = ctrl_q.m2reg;
  assign bus.e_wmem         = ctrl_q.wmem;
  assign bus.e_aluimm       = ctrl_q.aluimm;
  assign bus.e_aluc         = ctrl_q.aluc;
  assign bus.e_dest         = dest_q;
  assign bus.e_qa           = qa_q;
  assign bus.e_qb           = qb_q;
  assign bus.e_imm          = imm_q;
  assign bus.load_use_stall = load_use;
  assign bus.bubble_cnt     = cnt_q;

endmodule

// File: tb/tb_id_exe_stage.sv
// Bench for id_exe_stage: directed scenarios plus randomized traffic against
// a behavioural model; a second instance with a 2-bit counter shares stimulus.
module tb_id_exe_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_exe_stage_if #(.DATA_W(DW), .RA_W(AW), .ALUC_W(CW), .CNT_W(16)) bus ();
  id_exe_stage_if #(.DATA_W(DW), .RA_W(AW), .ALUC_W(CW), .CNT_W(2))  bus_s ();

  assign bus_s.id_valid   = bus.id_valid;
  assign bus_s.id_wreg    = bus.id_wreg;
  assign bus_s.id_m2reg   = bus.id_m2reg;
  assign bus_s.id_wmem    = bus.id_wmem;
  assign bus_s.id_aluimm  = bus.id_aluimm;
  assign bus_s.id_aluc    = bus.id_aluc;
  assign bus_s.id_rs      = bus.id_rs;
  assign bus_s.id_rt      = bus.id_rt;
  assign bus_s.id_uses_rt = bus.id_uses_rt;
  assign bus_s.id_dest    = bus.id_dest;
  assign bus_s.id_qa      = bus.id_qa;
  assign bus_s.id_qb      = bus.id_qb;
  assign bus_s.id_imm     = bus.id_imm;
  assign bus_s.flush      = bus.flush;
  assign bus_s.ext_stall  = bus.ext_stall;
  assign bus_s.m_wreg     = bus.m_wreg;
  assign bus_s.m_dest     = bus.m_dest;
  assign bus_s.m_res      = bus.m_res;
  assign bus_s.w_wreg     = bus.w_wreg;
  assign bus_s.w_dest     = bus.w_dest;
  assign bus_s.w_data     = bus.w_data;

  id_exe_stage #(.DATA_W(DW), .RA_W(AW), .CNT_W(16)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  id_exe_stage #(.DATA_W(DW), .RA_W(AW), .CNT_W(2)) dut_s (
    .clk (clk), .rst (rst), .bus (bus_s)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model of the execute-side registers.
  logic          x_valid, x_wreg, x_m2reg, x_wmem, x_aluimm;
  logic [CW-1:0] x_aluc;
  logic [AW-1:0] x_dest;
  logic [DW-1:0] x_qa, x_qb, x_imm;
  int            x_cnt, x_cnt2;

  function automatic logic model_lus();
    return x_valid && x_wreg && x_m2reg && (x_dest != 0) && bus.id_valid &&
           ((x_dest == bus.id_rs) || (bus.id_uses_rt && (x_dest == bus.id_rt)));
  endfunction

  function automatic logic [DW-1:0] model_fwd(input logic [AW-1:0] src, input logic [DW-1:0] rf);
    if (src == 0) return rf;
    if (bus.m_wreg && bus.m_dest == src) return bus.m_res;
    if (bus.w_wreg && bus.w_dest == src) return bus.w_data;
    return rf;
  endfunction

  function automatic logic [109:0] exp_e();
    return {x_valid, x_wreg, x_m2reg, x_wmem, x_aluimm, x_aluc, x_dest, x_qa, x_qb, x_imm};
  endfunction

  function automatic logic [109:0] act_e();
    return {bus.e_valid, bus.e_wreg, bus.e_m2reg, bus.e_wmem, bus.e_aluimm, bus.e_aluc,
            bus.e_dest, bus.e_qa, bus.e_qb, bus.e_imm};
  endfunction

  function automatic logic [109:0] act_e_s();
    return {bus_s.e_valid, bus_s.e_wreg, bus_s.e_m2reg, bus_s.e_wmem, bus_s.e_aluimm,
            bus_s.e_aluc, bus_s.e_dest, bus_s.e_qa, bus_s.e_qb, bus_s.e_imm};
  endfunction

  // Advance one clock: model computes its next state from the pre-edge view.
  task automatic tick();
    logic          n_valid, n_wreg, n_m2reg, n_wmem, n_aluimm;
    logic [CW-1:0] n_aluc;
    logic [AW-1:0] n_dest;
    logic [DW-1:0] n_qa, n_qb, n_imm;
    int            n_cnt, n_cnt2;
    {n_valid, n_wreg, n_m2reg, n_wmem, n_aluimm, n_aluc, n_dest, n_qa, n_qb, n_imm} = exp_e();
    n_cnt  = x_cnt;
    n_cnt2 = x_cnt2;
    if (rst) begin
      {n_valid, n_wreg, n_m2reg, n_wmem, n_aluimm, n_aluc, n_dest, n_qa, n_qb, n_imm} = '0;
      n_cnt  = 0;
      n_cnt2 = 0;
    end else if (bus.ext_stall) begin
      n_cnt = x_cnt;
    end else if (bus.flush || model_lus()) begin
      {n_valid, n_wreg, n_m2reg, n_wmem, n_aluimm, n_aluc, n_dest, n_qa, n_qb, n_imm} = '0;
      n_cnt  = (x_cnt < 65535) ? x_cnt + 1 : x_cnt;
      n_cnt2 = (x_cnt2 < 3) ? x_cnt2 + 1 : x_cnt2;
    end else begin
      n_valid  = bus.id_valid;
      n_wreg   = bus.id_wreg;
      n_m2reg  = bus.id_m2reg;
      n_wmem   = bus.id_wmem;
      n_aluimm = bus.id_aluimm;
      n_aluc   = bus.id_aluc;
      n_dest   = bus.id_dest;
      n_qa     = model_fwd(bus.id_rs, bus.id_qa);
      n_qb     = model_fwd(bus.id_rt, bus.id_qb);
      n_imm    = bus.id_imm;
    end
    @(posedge clk);
    {x_valid, x_wreg, x_m2reg, x_wmem, x_aluimm, x_aluc, x_dest, x_qa, x_qb, x_imm} =
      {n_valid, n_wreg, n_m2reg, n_wmem, n_aluimm, n_aluc, n_dest, n_qa, n_qb, n_imm};
    x_cnt  = n_cnt;
    x_cnt2 = n_cnt2;
    #1;
  endtask

  task automatic set_idle();
    rst = 1'b0;
    bus.id_valid = 0; bus.id_wreg = 0; bus.id_m2reg = 0; bus.id_wmem = 0;
    bus.id_aluimm = 0; bus.id_aluc = '0; bus.id_rs = '0; bus.id_rt = '0;
    bus.id_uses_rt = 0; bus.id_dest = '0; bus.id_qa = '0; bus.id_qb = '0;
    bus.id_imm = '0; bus.flush = 0; bus.ext_stall = 0;
    bus.m_wreg = 0; bus.m_dest = '0; bus.m_res = '0;
    bus.w_wreg = 0; bus.w_dest = '0; bus.w_data = '0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    bus.id_valid = 1; bus.id_wreg = 1; bus.id_qa = 32'h1234_5678; bus.id_dest = 5'd9;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (act_e() !== '0) begin
      $display("FAIL reset_outputs: got %h expected 0", act_e()); n_fail++;
    end
    n_cmp++;
    if (bus.bubble_cnt !== 16'd0 || bus_s.bubble_cnt !== 2'd0) begin
      $display("FAIL reset_cnt: got %0d/%0d expected 0/0", bus.bubble_cnt, bus_s.bubble_cnt); n_fail++;
    end
    n_cmp++;
    if (bus.load_use_stall !== 1'b0) begin
      $display("FAIL reset_lus: got %b expected 0", bus.load_use_stall); n_fail++;
    end
  endtask

  task automatic test_capture();
    do_reset();
    bus.id_valid = 1; bus.id_wreg = 1; bus.id_aluc = 4'h5; bus.id_rs = 5'd1; bus.id_rt = 5'd2;
    bus.id_uses_rt = 1; bus.id_qa = 32'h11; bus.id_qb = 32'h22; bus.id_imm = 32'hFFFF_FFF0;
    bus.id_dest = 5'd3;
    tick();
    n_cmp++;
    if (bus.e_qa !== 32'h11 || bus.e_qb !== 32'h22 || bus.e_imm !== 32'hFFFF_FFF0) begin
      $display("FAIL capture_data: got %h %h %h expected 11 22 fffffff0", bus.e_qa, bus.e_qb, bus.e_imm);
      n_fail++;
    end
    n_cmp++;
    if (bus.e_dest !== 5'd3 || bus.e_valid !== 1'b1 || bus.e_wreg !== 1'b1 || bus.e_aluc !== 4'h5) begin
      $display("FAIL capture_ctrl: got dest=%0d v=%b w=%b aluc=%h expected 3 1 1 5",
               bus.e_dest, bus.e_valid, bus.e_wreg, bus.e_aluc);
      n_fail++;
    end
    n_cmp++;
    if (act_e() !== exp_e()) begin
      $display("FAIL capture_model: got %h expected %h", act_e(), exp_e()); n_fail++;
    end
  endtask

  task automatic test_load_use();
    do_reset();
    bus.id_valid = 1; bus.id_wreg = 1; bus.id_m2reg = 1; bus.id_dest = 5'd5;
    tick();
    bus.id_m2reg = 0; bus.id_dest = 5'd6; bus.id_rs = 5'd5; bus.id_rt = 5'd2;
    bus.id_uses_rt = 1; bus.id_qa = 32'h1234;
    #1;
    n_cmp++;
    if (bus.load_use_stall !== 1'b1) begin
      $display("FAIL lu_detect: got %b expected 1", bus.load_use_stall); n_fail++;
    end
    tick();
    n_cmp++;
    if (bus.e_valid !== 1'b0 || bus.e_m2reg !== 1'b0 || bus.e_qa !== 32'h0 || bus.bubble_cnt !== 16'd1) begin
      $display("FAIL lu_bubble: got v=%b m2r=%b qa=%h cnt=%0d expected 0 0 0 1",
               bus.e_valid, bus.e_m2reg, bus.e_qa, bus.bubble_cnt);
      n_fail++;
    end
    bus.m_wreg = 1; bus.m_dest = 5'd5; bus.m_res = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if (bus.load_use_stall !== 1'b0) begin
      $display("FAIL lu_release: got %b expected 0", bus.load_use_stall); n_fail++;
    end
    tick();
    n_cmp++;
    if (bus.e_valid !== 1'b1 || bus.e_qa !== 32'hDEAD_BEEF || bus.bubble_cnt !== 16'd1) begin
      $display("FAIL lu_forward: got v=%b qa=%h cnt=%0d expected 1 deadbeef 1",
               bus.e_valid, bus.e_qa, bus.bubble_cnt);
      n_fail++;
    end
    bus.m_wreg = 0; bus.id_m2reg = 1; bus.id_dest = 5'd5; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
    tick();
    bus.id_m2reg = 0; bus.id_dest = 5'd7; bus.id_rs = 5'd1; bus.id_rt = 5'd5; bus.id_uses_rt = 1;
    #1;
    n_cmp++;
    if (bus.load_use_stall !== 1'b1) begin
      $display("FAIL lu_rt_used: got %b expected 1", bus.load_use_stall); n_fail++;
    end
    bus.id_uses_rt = 0;
    #1;
    n_cmp++;
    if (bus.load_use_stall !== 1'b0) begin
      $display("FAIL lu_rt_unused: got %b expected 0", bus.load_use_stall); n_fail++;
    end
    tick();
    n_cmp++;
    if (bus.e_valid !== 1'b1 || bus.bubble_cnt !== 16'd1) begin
      $display("FAIL lu_no_bubble: got v=%b cnt=%0d expected 1 1", bus.e_valid, bus.bubble_cnt); n_fail++;
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    bus.id_valid = 1; bus.id_wreg = 1; bus.id_rs = 5'd7; bus.id_rt = 5'd7; bus.id_uses_rt = 1;
    bus.m_wreg = 1; bus.w_wreg = 1; bus.m_dest = 5'd7; bus.w_dest = 5'd7;
    bus.m_res = 32'hAA; bus.w_data = 32'hBB; bus.id_qa = 32'hCC; bus.id_qb = 32'hDD;
    tick();
    n_cmp++;
    if (bus.e_qa !== 32'hAA || bus.e_qb !== 32'hAA) begin
      $display("FAIL fwd_mem: got %h %h expected aa aa", bus.e_qa, bus.e_qb); n_fail++;
    end
    bus.m_wreg = 0;
    tick();
    n_cmp++;
    if (bus.e_qa !== 32'hBB || bus.e_qb !== 32'hBB) begin
      $display("FAIL fwd_wb: got %h %h expected bb bb", bus.e_qa, bus.e_qb); n_fail++;
    end
    bus.m_wreg = 1; bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.m_dest = 5'd0; bus.w_dest = 5'd0;
    tick();
    n_cmp++;
    if (bus.e_qa !== 32'hCC || bus.e_qb !== 32'hDD) begin
      $display("FAIL fwd_r0: got %h %h expected cc dd", bus.e_qa, bus.e_qb); n_fail++;
    end
    bus.id_rs = 5'd3; bus.id_rt = 5'd7; bus.id_uses_rt = 0; bus.m_dest = 5'd7;
    tick();
    n_cmp++;
    if (bus.e_qa !== 32'hCC || bus.e_qb !== 32'hAA) begin
      $display("FAIL fwd_store_rt: got %h %h expected cc aa", bus.e_qa, bus.e_qb); n_fail++;
    end
  endtask

  task automatic test_stall_flush();
    do_reset();
    bus.id_valid = 1; bus.id_wreg = 1; bus.id_qa = 32'h55; bus.id_dest = 5'd9;
    tick();
    bus.ext_stall = 1; bus.flush = 1; bus.id_qa = 32'h66; bus.id_dest = 5'd10;
    tick();
    n_cmp++;
    if (bus.e_valid !== 1'b1 || bus.e_qa !== 32'h55 || bus.e_dest !== 5'd9 || bus.bubble_cnt !== 16'd0) begin
      $display("FAIL stall_hold: got v=%b qa=%h dest=%0d cnt=%0d expected 1 55 9 0",
               bus.e_valid, bus.e_qa, bus.e_dest, bus.bubble_cnt);
      n_fail++;
    end
    bus.ext_stall = 0;
    tick();
    n_cmp++;
    if (bus.e_valid !== 1'b0 || bus.e_qa !== 32'h0 || bus.e_dest !== 5'd0 || bus.bubble_cnt !== 16'd1) begin
      $display("FAIL flush_bubble: got v=%b qa=%h dest=%0d cnt=%0d expected 0 0 0 1",
               bus.e_valid, bus.e_qa, bus.e_dest, bus.bubble_cnt);
      n_fail++;
    end
    bus.flush = 0; bus.id_m2reg = 1; bus.id_dest = 5'd4;
    tick();
    bus.id_m2reg = 0; bus.id_dest = 5'd8; bus.id_rs = 5'd4; bus.flush = 1;
    tick();
    n_cmp++;
    if (bus.e_valid !== 1'b0 || bus.bubble_cnt !== 16'd2) begin
      $display("FAIL flush_and_lu_once: got v=%b cnt=%0d expected 0 2", bus.e_valid, bus.bubble_cnt);
      n_fail++;
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp2 [4];
    exp2[0] = 2'd1; exp2[1] = 2'd2; exp2[2] = 2'd3; exp2[3] = 2'd3;
    do_reset();
    bus.flush = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (bus_s.bubble_cnt !== exp2[i] || bus.bubble_cnt !== 16'(i + 1)) begin
        $display("FAIL saturate_%0d: got %0d/%0d expected %0d/%0d",
                 i, bus_s.bubble_cnt, bus.bubble_cnt, exp2[i], i + 1);
        n_fail++;
      end
    end
    bus.flush = 0;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    bus.flush = 1;
    tick();
    bus.flush = 0; bus.id_valid = 1; bus.id_wreg = 1; bus.id_m2reg = 1; bus.id_dest = 5'd5;
    tick();
    bus.id_m2reg = 0; bus.id_dest = 5'd6; bus.id_rs = 5'd5; bus.ext_stall = 1;
    tick();
    n_cmp++;
    if (bus.load_use_stall !== 1'b1 || bus.bubble_cnt !== 16'd1) begin
      $display("FAIL held_lus: got %b cnt=%0d expected 1 1", bus.load_use_stall, bus.bubble_cnt); n_fail++;
    end
    rst = 1; bus.flush = 1;
    tick();
    n_cmp++;
    if (act_e() !== '0 || bus.bubble_cnt !== 16'd0 || bus.load_use_stall !== 1'b0) begin
      $display("FAIL reset_mid_stall: got e=%h cnt=%0d lus=%b expected 0 0 0",
               act_e(), bus.bubble_cnt, bus.load_use_stall);
      n_fail++;
    end
    set_idle();
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      rst            = ($urandom_range(0, 59) == 0);
      bus.id_valid   = ($urandom_range(0, 3) != 0);
      bus.id_wreg    = ($urandom_range(0, 3) != 0);
      bus.id_m2reg   = ($urandom_range(0, 2) == 0);
      bus.id_wmem    = $urandom_range(0, 1);
      bus.id_aluimm  = $urandom_range(0, 1);
      bus.id_aluc    = 4'($urandom_range(0, 15));
      bus.id_rs      = 5'($urandom_range(0, 7));
      bus.id_rt      = 5'($urandom_range(0, 7));
      bus.id_uses_rt = $urandom_range(0, 1);
      bus.id_dest    = 5'($urandom_range(0, 7));
      bus.id_qa      = $urandom;
      bus.id_qb      = $urandom;
      bus.id_imm     = $urandom;
      bus.flush      = ($urandom_range(0, 9) == 0);
      bus.ext_stall  = ($urandom_range(0, 7) == 0);
      bus.m_wreg     = $urandom_range(0, 1);
      bus.m_dest     = 5'($urandom_range(0, 7));
      bus.m_res      = $urandom;
      bus.w_wreg     = $urandom_range(0, 1);
      bus.w_dest     = 5'($urandom_range(0, 7));
      bus.w_data     = $urandom;
      #1;
      n_cmp++;
      if (bus.load_use_stall !== model_lus() || bus_s.load_use_stall !== model_lus()) begin
        if (bad < 10) $display("FAIL rand_lus c=%0d: got %b/%b expected %b",
                               c, bus.load_use_stall, bus_s.load_use_stall, model_lus());
        n_fail++; bad++;
      end
      tick();
      n_cmp++;
      if (act_e() !== exp_e() || act_e_s() !== exp_e()) begin
        if (bad < 10) $display("FAIL rand_regs c=%0d: got %h expected %h", c, act_e(), exp_e());
        n_fail++; bad++;
      end
      n_cmp++;
      if (bus.bubble_cnt !== 16'(x_cnt) || bus_s.bubble_cnt !== 2'(x_cnt2)) begin
        if (bad < 10) $display("FAIL rand_cnt c=%0d: got %0d/%0d expected %0d/%0d",
                               c, bus.bubble_cnt, bus_s.bubble_cnt, x_cnt, x_cnt2);
        n_fail++; bad++;
      end
    end
    set_idle();
  endtask

  initial begin
    {x_valid, x_wreg, x_m2reg, x_wmem, x_aluimm, x_aluc, x_dest, x_qa, x_qb, x_imm} = '0;
    x_cnt  = 0;
    x_cnt2 = 0;
    set_idle();
    #1;
    test_reset();
    test_capture();
    test_load_use();
    test_forwarding();
    test_stall_flush();
    test_saturation();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
